if_id_ctrl: RTL

IF_ID_CTRL -- requirements
Module: if_id_ctrl

---
 rtl/if_id_pkg.sv | 14 +
 rtl/if_id_hazard_det.sv | 15 +
 rtl/if_id_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// if_id_pkg: shared state encoding, instruction field positions and constants for the IF/ID controller.
package if_id_pkg;
  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;
  localparam logic [4:0] OP_LOAD = 5'b00011;
  localparam int OP_MSB = 26;
  localparam int OP_LSB = 22;
  localparam int RD_MSB = 21;
  localparam int RD_LSB = 18;
  localparam int RS1_MSB = 17;
  localparam int RS1_LSB = 14;
  localparam int RS2_MSB = 13;
  localparam int RS2_LSB = 10;
  localparam logic [26:0] NOP = 27'd0;
endpackage

// File: rtl/if_id_hazard_det.sv
// if_id_hazard_det: combinational load-use comparator between the IF/ID instruction and the incoming one.
module if_id_hazard_det
  import if_id_pkg::*;
(
  input  logic       en_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_op_i,
  input  logic [3:0] id_rd_i,
  input  logic [3:0] rs1_i,
  input  logic [3:0] rs2_i,
  output logic       hazard_o
);
  assign hazard_o = en_i && id_valid_i && id_op_i == OP_LOAD && id_rd_i != 4'd0 &&
                    (rs1_i == id_rd_i || rs2_i == id_rd_i);
endmodule

// File: rtl/if_id_ctrl.sv
// if_id_ctrl: IF/ID pipeline register with load-use stall, memory stall and branch flush control.
// Load-use detection and LU_STALL are compiled in only when IF_ID_HAZARD_EN is defined.
module if_id_ctrl
  import if_id_pkg::*;
#(
  parameter int DATA_WIDTH = 27,
  parameter int LU_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_Pc,
  input  logic [DATA_WIDTH-1:0] i_Instruction,
  input  logic                  i_Mem_Busy,
  input  logic                  i_Ex_Branch_Taken,
  input  logic [DATA_WIDTH-1:0] i_Ex_Branch_Address,
  output logic                  o_Freeze,
  output logic                  o_Branch_Taken,
  output logic [DATA_WIDTH-1:0] o_Branch_Address,
  output logic [DATA_WIDTH-1:0] o_Id_Pc,
  output logic [DATA_WIDTH-1:0] o_Id_Instruction,
  output logic                  o_Id_Valid
);
`ifdef IF_ID_HAZARD_EN
  localparam logic HZ_EN = 1'b1;
`else
  localparam logic HZ_EN = 1'b0;
`endif
  localparam logic [DATA_WIDTH-1:0] BUB = DATA_WIDTH'(NOP);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, ins_q, ins_d, ba_q, ba_d;
  logic vld_q, vld_d, bt_q, bt_d, hz, lu, bub;
  if_id_hazard_det u_hazard_det (
    .en_i      (HZ_EN),
    .id_valid_i(vld_q),
    .id_op_i   (ins_q[OP_MSB:OP_LSB]),
    .id_rd_i   (ins_q[RD_MSB:RD_LSB]),
    .rs1_i     (i_Instruction[RS1_MSB:RS1_LSB]),
    .rs2_i     (i_Instruction[RS2_MSB:RS2_LSB]),
    .hazard_o  (hz)
  );
  assign lu = (hz && state_q == RUN) || state_q == LU_STALL;
  assign bub = lu || state_q == FLUSH;
  assign o_Freeze = !reset && (i_Mem_Busy || lu);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pc_d = pc_q;
    ins_d = ins_q;
    vld_d = vld_q;
    bt_d = i_Ex_Branch_Taken;
    ba_d = i_Ex_Branch_Taken ? i_Ex_Branch_Address : '0;
    if (i_Ex_Branch_Taken) begin
      state_d = FLUSH;
      cnt_d = 2'd0;
      pc_d = '0;
      ins_d = BUB;
      vld_d = 1'b0;
    end else if (!i_Mem_Busy) begin
      pc_d = bub ? '0 : i_Pc;
      ins_d = bub ? BUB : i_Instruction;
      vld_d = !bub;
      state_d = state_q == RUN ? ((hz && LU_BUBBLES > 1) ? LU_STALL : RUN) :
                (state_q == LU_STALL && cnt_q > 2'd1) ? LU_STALL : RUN;
      cnt_d = state_q == RUN ? (hz ? 2'(LU_BUBBLES - 1) : 2'd0) :
              state_q == LU_STALL ? cnt_q - 2'd1 : 2'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= 2'd0;
      pc_q <= '0;
      ins_q <= '0;
      vld_q <= 1'b0;
      bt_q <= 1'b0;
      ba_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      ins_q <= ins_d;
      vld_q <= vld_d;
      bt_q <= bt_d;
      ba_q <= ba_d;
    end
  end
  assign o_Branch_Taken = bt_q;
  assign o_Branch_Address = ba_q;
  assign o_Id_Pc = pc_q;
  assign o_Id_Instruction = ins_q;
  assign o_Id_Valid = vld_q;
endmodule
